// File: rtl/fiber_pkg.sv
// Shared defaults, field widths and FSM encoding for the fiber TX frame scheduler.
package fiber_pkg;

    localparam int DEF_CLK_DIV     = 9;
    localparam int DEF_FRAME_BITS  = 80;
    localparam int DEF_ADC_SLOT    = 12;
    localparam int DEF_ADC_TIMEOUT = 64;

    localparam int VOLT_W = 12;
    localparam int ERR_W  = 12;
    localparam int INFO_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CONV,
        ST_HOLD,
        ST_LOAD
    } fiber_state_e;

endpackage

// File: rtl/fiber_bit_timer.sv
// Bit-rate divider and frame slot counter: bit_tick every CLK_DIV+1 clocks,
// slot wraps FRAME_BITS-1 -> 0, frame_tick marks the last bit of a frame.
module fiber_bit_timer #(
    parameter int CLK_DIV    = 9,
    parameter int FRAME_BITS = 80
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          bit_tick,
    output logic [$clog2(FRAME_BITS)-1:0] slot,
    output logic                          frame_tick
);

    localparam int DIV_W  = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int SLOT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              tick;

    always_comb begin
        tick   = (div_q == DIV_MAX);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        slot_d = slot_q;
        if (tick) slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            slot_q <= '0;
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
        end
    end

    // Gated so a CLK_DIV of 0 still shows no tick while held in reset.
    assign bit_tick   = tick & ~rst;
    assign slot       = slot_q;
    assign frame_tick = bit_tick & (slot_q == SLOT_MAX);

endmodule

// File: rtl/fiber_tx_sched.sv
// Frame scheduler: requests one ADC conversion per frame, gathers fault flags,
// and hands a {voltage, info} payload to the serializer at each frame boundary.
module fiber_tx_sched
    import fiber_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int ADC_SLOT    = DEF_ADC_SLOT,     // legal range 1..FRAME_BITS-1
    parameter int ADC_TIMEOUT = DEF_ADC_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VOLT_W-1:0] udc_volt,
    input  logic [ERR_W-1:0]  err_info,
    input  logic              modu_run,
    input  logic              byp_ok,
    input  logic              adc_done,
    input  logic              ser_ready,
    output logic              adc_start,
    output logic              bit_tick,
    output logic              ser_load,
    output logic [VOLT_W-1:0] ser_volt,
    output logic [INFO_W-1:0] ser_info,
    output logic              adc_to_err,
    output logic              ovr_err
);

    localparam int SLOT_W = $clog2(FRAME_BITS);
    localparam int TMO_W  = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam logic [SLOT_W-1:0] CONV_SLOT = SLOT_W'(ADC_SLOT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ADC_TIMEOUT - 1);

    logic [SLOT_W-1:0] slot;
    logic              frame_tick;

    fiber_bit_timer #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .bit_tick   (bit_tick),
        .slot       (slot),
        .frame_tick (frame_tick)
    );

    fiber_state_e      state_q, state_d;
    logic [VOLT_W-1:0] volt_q, volt_d;
    logic [ERR_W-1:0]  err_acc_q, err_acc_d;
    logic [VOLT_W-1:0] ser_volt_q, ser_volt_d;
    logic [INFO_W-1:0] ser_info_q, ser_info_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              adc_start_q, adc_start_d;
    logic              adc_to_err_q, adc_to_err_d;
    logic              ovr_err_q, ovr_err_d;
    logic              load_payload;

    always_comb begin
        state_d      = state_q;
        volt_d       = volt_q;
        err_acc_d    = err_acc_q | err_info;
        ser_volt_d   = ser_volt_q;
        ser_info_d   = ser_info_q;
        tmo_d        = '0;
        adc_start_d  = 1'b0;
        adc_to_err_d = adc_to_err_q;
        ovr_err_d    = ovr_err_q;
        load_payload = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bit_tick && slot == CONV_SLOT) begin
                    state_d     = ST_CONV;
                    adc_start_d = 1'b1;
                end
            end
            ST_CONV: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (adc_done) volt_d = udc_volt;
                // A done strobe wins over both timeout and the frame boundary.
                if (frame_tick) begin
                    if (!adc_done) adc_to_err_d = 1'b1;
                    load_payload = 1'b1;
                    state_d      = ST_LOAD;
                end else if (adc_done) begin
                    state_d = ST_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    adc_to_err_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (frame_tick) begin
                    load_payload = 1'b1;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ser_ready) begin
                    state_d = ST_WAIT;
                end else if (frame_tick) begin
                    ovr_err_d    = 1'b1;
                    load_payload = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Faults seen on the load clock itself are carried into the next frame.
        if (load_payload) begin
            ser_volt_d = volt_d;
            ser_info_d = {byp_ok, modu_run, err_acc_q};
            err_acc_d  = err_info;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            volt_q       <= '0;
            err_acc_q    <= '0;
            ser_volt_q   <= '0;
            ser_info_q   <= '0;
            tmo_q        <= '0;
            adc_start_q  <= 1'b0;
            adc_to_err_q <= 1'b0;
            ovr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            volt_q       <= volt_d;
            err_acc_q    <= err_acc_d;
            ser_volt_q   <= ser_volt_d;
            ser_info_q   <= ser_info_d;
            tmo_q        <= tmo_d;
            adc_start_q  <= adc_start_d;
            adc_to_err_q <= adc_to_err_d;
            ovr_err_q    <= ovr_err_d;
        end
    end

    assign adc_start  = adc_start_q;
    assign ser_load   = (state_q == ST_LOAD);
    assign ser_volt   = ser_volt_q;
    assign ser_info   = ser_info_q;
    assign adc_to_err = adc_to_err_q;
    assign ovr_err    = ovr_err_q;

endmodule
